// File: rtl/leg4_prog_loader.sv
// Writable 16x8 program memory for the leg4 CPU, loaded from a byte stream using
// framed, checksummed packets: A5, N (1..16), N data bytes, sum of data mod 256.
module leg4_prog_loader #(
    parameter int TIMEOUT_CYCLES = 27_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [3:0] fetch_addr,
    output logic [7:0] fetch_data,
    output logic       cpu_run,
    output logic       load_done,
    output logic       err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      HDR      = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHK,
        RUN
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [7:0]       acc_reg;
    logic [3:0]       idx_reg;
    logic [4:0]       len_reg;
    logic             cpu_run_reg;
    logic             load_done_reg;
    logic             err_reg;
    logic [7:0]       mem_reg [16];
    logic [15:0]      wr_sel;

    logic accept;
    logic in_frame;
    logic hdr_hit;
    logic data_wr;
    logic len_ok;
    logic last_data;
    logic timeout;

    assign rx_ready  = rst_n;
    assign accept    = rx_valid & rx_ready;
    assign in_frame  = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CHK);
    assign hdr_hit   = accept && (rx_data == HDR) && ((state_reg == IDLE) || (state_reg == RUN));
    assign data_wr   = accept && (state_reg == DATA);
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'd16);
    assign last_data = ({1'b0, idx_reg} == (len_reg - 5'd1));
    // A byte on the expiry cycle wins, so timeout only fires on an idle cycle.
    assign timeout   = in_frame && !accept && (cnt_reg == CNT_LAST);

    assign fetch_data = mem_reg[fetch_addr];
    assign cpu_run    = cpu_run_reg;
    assign load_done  = load_done_reg;
    assign err        = err_reg;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_wr_sel
            assign wr_sel[gi] = data_wr && (idx_reg == 4'(gi));
        end
    endgenerate

    // A header wipes the whole program so a short reload leaves no stale tail.
    always_ff @(posedge clk) begin
        if (!rst_n || hdr_hit) begin
            for (int i = 0; i < 16; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= rx_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= 8'h00;
            idx_reg       <= 4'd0;
            len_reg       <= 5'd0;
            cpu_run_reg   <= 1'b0;
            load_done_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;

            if (in_frame) begin
                if (accept) begin
                    cnt_reg <= '0;
                end else if (timeout) begin
                    cnt_reg   <= '0;
                    err_reg   <= 1'b1;
                    state_reg <= IDLE;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            case (state_reg)
                IDLE, RUN: begin
                    if (hdr_hit) begin
                        state_reg   <= LEN;
                        err_reg     <= 1'b0;
                        cpu_run_reg <= 1'b0;
                        acc_reg     <= 8'h00;
                        idx_reg     <= 4'd0;
                        cnt_reg     <= '0;
                    end
                end
                LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            len_reg   <= rx_data[4:0];
                            state_reg <= DATA;
                        end else begin
                            err_reg   <= 1'b1;
                            state_reg <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        acc_reg <= acc_reg + rx_data;
                        idx_reg <= idx_reg + 4'd1;
                        if (last_data) begin
                            state_reg <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (accept) begin
                        if (rx_data == acc_reg) begin
                            state_reg     <= RUN;
                            cpu_run_reg   <= 1'b1;
                            load_done_reg <= 1'b1;
                        end else begin
                            err_reg     <= 1'b1;
                            cpu_run_reg <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leg4_prog_loader.sv
// Bench for leg4_prog_loader: directed protocol scenarios with literal expectations,
// then random traffic, all checked every cycle against a frame-level model.
module tb_leg4_prog_loader;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] fetch_addr = 4'd0;
    logic       rx_ready;
    logic [7:0] fetch_data;
    logic       cpu_run;
    logic       load_done;
    logic       err;

    int n_pass = 0;
    int n_total = 0;
    bit started = 1'b0;

    leg4_prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    endtask

    // Frame-level model: bytes after the header are collected in a queue and the
    // outcome is decided from the queue length and contents.
    logic [7:0] m_mem [16];
    logic [7:0] m_frame [$];
    bit         m_in_frame = 1'b0;
    int         m_len = 0;
    int         m_idle = 0;
    bit         m_err = 1'b0;
    bit         m_run = 1'b0;
    bit         m_done = 1'b0;

    always @(posedge clk) begin
        int pos;
        logic [7:0] sum;
        m_done = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
            m_frame.delete();
            m_in_frame = 1'b0;
            m_idle = 0;
            m_err = 1'b0;
            m_run = 1'b0;
        end else if (rx_valid) begin
            if (!m_in_frame) begin
                if (rx_data == 8'hA5) begin
                    m_in_frame = 1'b1;
                    m_frame.delete();
                    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
                    m_err = 1'b0;
                    m_run = 1'b0;
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
                pos = m_frame.size();
                if (pos == 0) begin
                    if (rx_data == 8'd0 || rx_data > 8'd16) begin
                        m_err = 1'b1;
                        m_in_frame = 1'b0;
                    end else begin
                        m_len = int'(rx_data);
                    end
                end else if (pos <= m_len) begin
                    m_mem[pos-1] = rx_data;
                end else begin
                    sum = 8'h00;
                    for (int i = 1; i <= m_len; i++) sum = sum + m_frame[i];
                    if (sum == rx_data) begin
                        m_run = 1'b1;
                        m_done = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_in_frame = 1'b0;
                end
                m_frame.push_back(rx_data);
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TO) begin
                m_err = 1'b1;
                m_in_frame = 1'b0;
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rx_ready", {7'b0, rx_ready}, {7'b0, rst_n});
            chk("cpu_run", {7'b0, cpu_run}, {7'b0, m_run});
            chk("load_done", {7'b0, load_done}, {7'b0, m_done});
            chk("err", {7'b0, err}, {7'b0, m_err});
            chk("fetch_data", fetch_data, m_mem[fetch_addr]);
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        fetch_addr = 4'($urandom);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            fetch_addr = 4'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic peek(input logic [3:0] a, input logic [7:0] exp, input string name);
        fetch_addr = a;
        #1;
        chk(name, fetch_data, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic flags(input string name, input bit run, input bit done, input bit e);
        chk({name, ".cpu_run"}, {7'b0, cpu_run}, {7'b0, run});
        chk({name, ".load_done"}, {7'b0, load_done}, {7'b0, done});
        chk({name, ".err"}, {7'b0, err}, {7'b0, e});
    endtask

    task automatic gap();
        int g;
        g = ($urandom_range(0, 15) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 2));
        idle(g);
    endtask

    initial begin
        int kind;
        int n;
        logic [7:0] b;
        logic [7:0] s;

        // Reset state
        #1;
        @(posedge clk);
        #1;
        chk("reset.rx_ready", {7'b0, rx_ready}, 8'h00);
        flags("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("post_reset.rx_ready", {7'b0, rx_ready}, 8'h01);
        idle(2);
        $display("txn reset: cpu_run=%0b err=%0b", cpu_run, err);

        // Good load
        send(8'hA5); send(8'h03); send(8'h20); send(8'h08); send(8'hE8);
        flags("good.pre_chk", 1'b0, 1'b0, 1'b0);
        send(8'h10);
        flags("good.chk_edge", 1'b1, 1'b1, 1'b0);
        idle(1);
        flags("good.after", 1'b1, 1'b0, 1'b0);
        peek(4'd0, 8'h20, "good.mem0");
        peek(4'd1, 8'h08, "good.mem1");
        peek(4'd2, 8'hE8, "good.mem2");
        peek(4'd3, 8'h00, "good.mem3");
        $display("txn good load A5 03 20 08 E8 10: cpu_run=%0b err=%0b", cpu_run, err);

        // Noise in RUN, then reload
        send(8'h55);
        flags("noise", 1'b1, 1'b0, 1'b0);
        peek(4'd0, 8'h20, "noise.mem0");
        send(8'hA5);
        flags("reload.hdr", 1'b0, 1'b0, 1'b0);
        send(8'h01); send(8'hF0); send(8'hF0);
        flags("reload.done", 1'b1, 1'b1, 1'b0);
        peek(4'd0, 8'hF0, "reload.mem0");
        peek(4'd1, 8'h00, "reload.mem1");
        $display("txn noise 55 + reload A5 01 F0 F0: cpu_run=%0b err=%0b", cpu_run, err);

        // Bad checksum
        send(8'hA5); send(8'h01); send(8'hB1); send(8'h00);
        flags("badchk", 1'b0, 1'b0, 1'b1);
        peek(4'd0, 8'hB1, "badchk.mem0");
        $display("txn bad checksum A5 01 B1 00: cpu_run=%0b err=%0b", cpu_run, err);

        // Bad lengths
        send(8'hA5); send(8'h00);
        flags("len00", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) peek(4'(i), 8'h00, "len00.mem");
        send(8'hA5); send(8'h11);
        flags("len11", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) peek(4'(i), 8'h00, "len11.mem");
        $display("txn bad lengths 00 and 11: err=%0b", err);

        // Timeout: eighth idle cycle expires the frame
        send(8'hA5); send(8'h02); send(8'hB1);
        idle(TO - 1);
        flags("timeout.before", 1'b0, 1'b0, 1'b0);
        idle(1);
        flags("timeout.expired", 1'b0, 1'b0, 1'b1);
        $display("txn timeout after A5 02 B1: err=%0b", err);

        // Byte on the expiry cycle is accepted
        send(8'hA5); send(8'h02); send(8'hB1);
        idle(TO - 1);
        send(8'hB2);
        flags("expiry_byte", 1'b0, 1'b0, 1'b0);
        idle(TO - 1);
        send(8'h63);
        flags("expiry_load", 1'b1, 1'b1, 1'b0);
        $display("txn byte on expiry cycle: cpu_run=%0b err=%0b", cpu_run, err);

        // Reset mid-frame
        send(8'hA5); send(8'h04); send(8'hB1); send(8'hB2);
        pulse_reset();
        flags("midreset", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) peek(4'(i), 8'h00, "midreset.mem");
        send(8'hA5); send(8'h02); send(8'h12); send(8'h34); send(8'h46);
        flags("midreset.reload", 1'b1, 1'b1, 1'b0);
        peek(4'd0, 8'h12, "midreset.mem0");
        peek(4'd1, 8'h34, "midreset.mem1");
        peek(4'd2, 8'h00, "midreset.mem2");
        $display("txn reset mid-frame then A5 02 12 34 46: cpu_run=%0b err=%0b", cpu_run, err);

        // Random traffic
        for (int it = 0; it < 250; it++) begin
            kind = int'($urandom_range(0, 11));
            if (kind == 0) begin
                send(8'($urandom));
                $display("txn %0d noise byte: cpu_run=%0b err=%0b", it, cpu_run, err);
            end else if (kind == 1) begin
                send(8'hA5);
                gap();
                b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
                send(b);
                $display("txn %0d bad length %02h: err=%0b", it, b, err);
            end else if (kind == 2) begin
                pulse_reset();
                $display("txn %0d reset pulse", it);
            end else begin
                n = int'($urandom_range(1, 16));
                s = 8'h00;
                send(8'hA5);
                gap();
                send(8'(n));
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    s = s + b;
                    gap();
                    send(b);
                end
                gap();
                if ($urandom_range(0, 4) == 0) s = s + 8'h01;
                send(s);
                idle(int'($urandom_range(0, 2)));
                $display("txn %0d frame n=%0d: cpu_run=%0b err=%0b", it, n, cpu_run, err);
            end
        end

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/leg4_prog_loader.md
LEG4_PROG_LOADER -- requirements
Module: leg4_prog_loader

Writable 16x8 program memory for the leg4 CPU, filled from a byte stream (e.g. UART RX) with a framed, checksummed load protocol; CPU fetch reads it.

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 27_000_000, maximum clocks allowed between bytes inside a frame.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  incoming byte.
REQ-005 SHALL have port rx_valid  input  1  rx_data valid this cycle.
REQ-006 SHALL have port rx_ready  output  1  loader accepts the byte; transfer occurs when rx_valid and rx_ready are both high at a clk edge.
REQ-007 SHALL have port fetch_addr  input  4  CPU instruction address.
REQ-008 SHALL have port fetch_data  output  8  instruction at fetch_addr.
REQ-009 SHALL have port cpu_run  output  1  valid program present; CPU may execute.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse on successful load.
REQ-011 SHALL have port err  output  1  sticky error flag for the last frame.

Function
REQ-012 SHALL be a frame: header 0xA5, length byte N (valid 1..16), N data bytes, checksum byte = sum of data bytes mod 256.
REQ-013 SHALL use states IDLE, LEN, DATA, CHK, RUN.
REQ-014 SHALL hold rx_ready = 1 in every state; rx_ready = 0 only while rst_n = 0.
REQ-015 SHALL in IDLE or RUN, on an accepted 0xA5: go to LEN, clear all 16 locations to 0x00, clear err, drop cpu_run, clear checksum accumulator and write index.
REQ-016 SHALL in IDLE or RUN consume and ignore any accepted byte other than 0xA5, with no state change.
REQ-017 SHALL in LEN, on an accepted byte 1..16: latch N and go to DATA. Any other value: set err and go to IDLE.
REQ-018 SHALL in DATA write each accepted byte to mem[index] on the accepting edge, add it to the 8-bit accumulator with wrap, and increment index; after the Nth byte go to CHK.
REQ-019 SHALL in CHK, on an accepted byte equal to the accumulator: go to RUN, set cpu_run = 1, and pulse load_done for exactly the following cycle. On mismatch: set err, keep cpu_run = 0, go to IDLE. Written bytes remain in memory.
REQ-020 SHALL make fetch_data = mem[fetch_addr] combinationally; a write is visible on fetch_data the cycle after the accepting edge.
REQ-021 SHALL in LEN, DATA and CHK count idle cycles since the last accepted byte; when the count reaches TIMEOUT_CYCLES, set err and go to IDLE.
REQ-022 SHALL give an accepted byte on the expiry cycle priority over the timeout; the byte is processed and the counter resets.
REQ-023 SHALL keep the counter at 0 in IDLE and RUN, and size it to hold TIMEOUT_CYCLES without overflow.

Reset
REQ-024 SHALL on rst_n = 0 at a clk edge, in any state including mid-frame: set state to IDLE, all memory locations to 0x00, cpu_run = 0, load_done = 0, err = 0, counter = 0, accumulator = 0, index = 0.

Verification
REQ-025 SHALL cover a good load: bytes A5 03 20 08 E8 10 -> cpu_run = 1; load_done high for 1 cycle; fetch 0/1/2/3 = 20/08/E8/00; err = 0.
REQ-026 SHALL cover a bad checksum: A5 01 B1 00 -> err = 1; cpu_run = 0; state IDLE; fetch 0 = B1.
REQ-027 SHALL cover bad lengths: A5 00 -> err = 1; then A5 11 -> err = 1; memory all 00 after each.
REQ-028 SHALL cover timeout with TIMEOUT_CYCLES = 8: A5 02 B1 then 8 idle cycles -> err = 1 and IDLE. A byte arriving exactly on cycle 8 -> accepted, no err.
REQ-029 SHALL cover reload and noise: in RUN send 55 -> no change. Then A5 01 F0 F0 -> cpu_run drops on the header edge, returns to 1, fetch 0 = F0, fetch 1 = 00.
REQ-030 SHALL cover reset mid-frame: A5 04 B1 B2, then rst_n low 1 cycle -> all outputs at reset values, memory 00. Then a full good frame loads correctly.
